neuron_layer: RTL and testbench

Parametrised successor of the single-neuron MAC unit. Computes N_OUT neurons sequentially over a shared N_IN-element input vector, one signed multiply-accumulate per clock. Each neuron result is shifted, optionally ReLU-activated and saturated to OW bits. Input and weight memories are writable through a port, not only by bench preload. Results are streamed out and held in a readable result bank.

---
 rtl/neuron_layer.sv | 222 ++++++++++++++++++++++
 tb/tb_neuron_layer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer.sv
// neuron_layer: computes N_OUT neurons one after another over a shared
// N_IN-element input vector, one signed multiply-accumulate per clock.
// Each neuron sum is arithmetically shifted, optionally ReLU-clamped and
// saturated to OW bits, then streamed out and stored in a readable bank.
`timescale 1ns/1ps
module neuron_layer #(
    parameter int N_IN  = 16,
    parameter int DW    = 8,
    parameter int N_OUT = 4,
    parameter int OW    = 16,
    parameter int SHIFT = 0,
    localparam int IAW  = $clog2(N_IN),
    localparam int WAW  = $clog2(N_IN * N_OUT),
    localparam int NW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           act_relu,
    input  logic           in_we,
    input  logic [IAW-1:0] in_addr,
    input  logic           w_we,
    input  logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  wr_data,
    input  logic [NW-1:0]  rd_idx,
    output logic [OW-1:0]  rd_data,
    output logic [OW-1:0]  out,
    output logic [NW-1:0]  out_idx,
    output logic           out_valid,
    output logic           busy,
    output logic           ready
);

    // Accumulator is wide enough that N_IN full-scale products never overflow.
    localparam int AW = 2 * DW + $clog2(N_IN);
    // One guard bit above the wider of accumulator/output keeps the
    // saturation compare signed and exact.
    localparam int EW = ((AW > OW) ? AW : OW) + 1;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_start_d;
    logic signed [AW-1:0]  r_acc;
    logic [IAW-1:0]        r_i;
    logic [NW-1:0]         r_n;
    logic                  r_relu;
    logic [OW-1:0]         r_out;
    logic [NW-1:0]         r_out_idx;
    logic                  r_out_valid;
    logic                  r_ready;
    logic [OW-1:0]         r_rd_data;

    logic signed [DW-1:0]  r_in_mem [N_IN];
    logic signed [DW-1:0]  r_w_mem  [N_IN*N_OUT];
    logic [OW-1:0]         r_result [N_OUT];

    logic                  w_launch;
    logic                  w_last_i;
    logic                  w_last_n;
    logic                  w_busy;
    logic                  w_write_now;
    logic [WAW-1:0]        w_rd_addr;
    logic signed [DW-1:0]  w_in_op;
    logic signed [DW-1:0]  w_w_op;
    logic signed [2*DW-1:0] w_in_ext;
    logic signed [2*DW-1:0] w_w_ext;
    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]  w_prod_ext;
    logic signed [EW-1:0]  w_acc_ext;
    logic signed [EW-1:0]  w_shifted;
    logic signed [EW-1:0]  w_act;
    logic signed [EW-1:0]  w_sat;
    logic [OW-1:0]         w_result;

    // A run launches only on a low->high transition of start seen in IDLE.
    assign w_launch    = (r_state == S_IDLE) && start && !r_start_d;
    assign w_last_i    = (int'(r_i) == N_IN - 1);
    assign w_last_n    = (int'(r_n) == N_OUT - 1);
    assign w_busy      = (r_state == S_MAC) || (r_state == S_WRITE);
    assign w_write_now = (r_state == S_WRITE);

    // Operand fetch: weight row n, column i.
    assign w_rd_addr  = WAW'(int'(r_n) * N_IN + int'(r_i));
    assign w_in_op    = r_in_mem[r_i];
    assign w_w_op     = r_w_mem[w_rd_addr];
    assign w_in_ext   = {{DW{w_in_op[DW-1]}}, w_in_op};
    assign w_w_ext    = {{DW{w_w_op[DW-1]}}, w_w_op};
    assign w_prod     = w_in_ext * w_w_ext;
    assign w_prod_ext = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};

    // Post-processing: arithmetic shift, optional ReLU, saturation.
    assign w_acc_ext = {{(EW-AW){r_acc[AW-1]}}, r_acc};
    assign w_shifted = w_acc_ext >>> SHIFT;
    assign w_act     = (r_relu && w_shifted[EW-1]) ? '0 : w_shifted;
    assign w_sat     = (w_act > SAT_MAX) ? SAT_MAX :
                       (w_act < SAT_MIN) ? SAT_MIN : w_act;
    assign w_result  = w_sat[OW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_next = S_MAC;
            S_MAC:   if (w_last_i) w_state_next = S_WRITE;
            S_WRITE: w_state_next = w_last_n ? S_DONE : S_MAC;
            S_DONE:  if (!start) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Start edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= start;
        end
    end

    // MAC datapath, neuron sequencing and streamed result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_i         <= '0;
            r_n         <= '0;
            r_relu      <= 1'b0;
            r_out       <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_n     <= '0;
                        r_relu  <= act_relu;
                        r_ready <= 1'b0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_i   <= w_last_i ? '0 : r_i + 1'b1;
                end
                S_WRITE: begin
                    r_out       <= w_result;
                    r_out_idx   <= r_n;
                    r_out_valid <= 1'b1;
                    if (!w_last_n) begin
                        r_n   <= r_n + 1'b1;
                        r_acc <= '0;
                        r_i   <= '0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result bank plus registered read port; a read of the entry being
    // written this cycle forwards the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) begin
                r_result[k] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (w_write_now) begin
                r_result[r_n] <= w_result;
            end
            if (int'(rd_idx) < N_OUT) begin
                r_rd_data <= (w_write_now && (rd_idx == r_n)) ? w_result : r_result[rd_idx];
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    // Input and weight memories: writable only while no run is active,
    // out-of-range addresses ignored, contents survive reset.
    always_ff @(posedge clk) begin
        if (!w_busy) begin
            if (in_we && (int'(in_addr) < N_IN)) begin
                r_in_mem[in_addr] <= wr_data;
            end
            if (w_we && (int'(w_addr) < N_IN * N_OUT)) begin
                r_w_mem[w_addr] <= wr_data;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign out       = r_out;
    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign busy      = w_busy;
    assign ready     = r_ready;

endmodule

// File: tb/tb_neuron_layer.sv
// Directed testbench for neuron_layer: default instance (16 inputs,
// 4 neurons, no shift) plus a SHIFT=4 single-neuron instance.
`timescale 1ns/1ps
module tb_neuron_layer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, act_relu, in_we, w_we;
    logic [3:0]  in_addr;
    logic [5:0]  w_addr;
    logic [7:0]  wr_data;
    logic [1:0]  rd_idx;
    logic [15:0] rd_data, out;
    logic [1:0]  out_idx;
    logic        out_valid, busy, ready;

    logic        s_start, s_act_relu, s_in_we, s_w_we;
    logic [3:0]  s_in_addr, s_w_addr;
    logic [7:0]  s_wr_data;
    logic [0:0]  s_rd_idx, s_out_idx;
    logic [15:0] s_rd_data, s_out;
    logic        s_out_valid, s_busy, s_ready;

    neuron_layer u_dut (
        .clk(clk), .rst(rst), .start(start), .act_relu(act_relu),
        .in_we(in_we), .in_addr(in_addr), .w_we(w_we), .w_addr(w_addr),
        .wr_data(wr_data), .rd_idx(rd_idx), .rd_data(rd_data), .out(out),
        .out_idx(out_idx), .out_valid(out_valid), .busy(busy), .ready(ready)
    );

    neuron_layer #(.N_IN(16), .DW(8), .N_OUT(1), .OW(16), .SHIFT(4)) u_dut_s4 (
        .clk(clk), .rst(rst), .start(s_start), .act_relu(s_act_relu),
        .in_we(s_in_we), .in_addr(s_in_addr), .w_we(s_w_we), .w_addr(s_w_addr),
        .wr_data(s_wr_data), .rd_idx(s_rd_idx), .rd_data(s_rd_data), .out(s_out),
        .out_idx(s_out_idx), .out_valid(s_out_valid), .busy(s_busy), .ready(s_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] cap_val [8];
    logic [1:0]  cap_idx [8];
    int          cap_cyc [8];
    logic [15:0] cap_rd  [8];
    int          n_pulses;
    int          ready_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_both(input logic ie, input logic [3:0] ia, input logic we_,
                           input logic [5:0] wa, input logic [7:0] d);
        in_we = ie; in_addr = ia; w_we = we_; w_addr = wa; wr_data = d;
        tick();
        in_we = 1'b0; w_we = 1'b0;
    endtask

    task automatic load_all(input logic [7:0] iv, input logic [7:0] wv);
        for (int a = 0; a < 16; a++) wr_both(1'b1, a[3:0], 1'b0, 6'd0, iv);
        for (int a = 0; a < 64; a++) wr_both(1'b0, 4'd0, 1'b1, a[5:0], wv);
    endtask

    task automatic set_neuron_w(input int n, input logic [7:0] v);
        int a;
        for (int i = 0; i < 16; i++) begin
            a = n * 16 + i;
            wr_both(1'b0, 4'd0, 1'b1, a[5:0], v);
        end
    endtask

    // Launch one run and capture every result pulse; cycle numbers count
    // edges after the launch edge E0. Optionally issue a weight write at a
    // given cycle (while the run is busy).
    task automatic run_capture(input logic relu, input int bwr_cyc,
                               input logic [5:0] bwr_addr, input logic [7:0] bwr_val);
        start = 1'b0;
        tick();
        tick();
        act_relu  = relu;
        start     = 1'b1;
        n_pulses  = 0;
        ready_cyc = -1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (c == bwr_cyc) begin
                w_we = 1'b1; w_addr = bwr_addr; wr_data = bwr_val;
            end else begin
                w_we = 1'b0;
            end
            if (out_valid) begin
                if (n_pulses < 8) begin
                    cap_val[n_pulses] = out;
                    cap_idx[n_pulses] = out_idx;
                    cap_cyc[n_pulses] = c;
                    cap_rd[n_pulses]  = rd_data;
                end
                n_pulses++;
            end
            if (ready) begin
                ready_cyc = c;
                break;
            end
        end
        w_we  = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (out !== 16'd0)      begin errors++; $display("FAIL reset_out got %h exp 0000", out); end
        checks++; if (out_idx !== 2'd0)   begin errors++; $display("FAIL reset_out_idx got %0d exp 0", out_idx); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (rd_data !== 16'd0)  begin errors++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
        $display("reset: out=%h busy=%b ready=%b", out, busy, ready);
    endtask

    task automatic test_basic();
        load_all(8'd1, 8'd1);
        run_capture(1'b0, -1, 6'd0, 8'd0);
        checks++; if (n_pulses !== 4) begin errors++; $display("FAIL basic_pulses got %0d exp 4", n_pulses); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (cap_val[k] !== 16'd16) begin errors++; $display("FAIL basic_out%0d got %h exp 0010", k, cap_val[k]); end
            checks++; if (cap_idx[k] !== 2'(k)) begin errors++; $display("FAIL basic_idx%0d got %0d exp %0d", k, cap_idx[k], k); end
            checks++; if (cap_cyc[k] !== 17 * (k + 1)) begin errors++; $display("FAIL basic_cyc%0d got %0d exp %0d", k, cap_cyc[k], 17 * (k + 1)); end
            $display("basic: neuron %0d out=%h at cycle %0d", k, cap_val[k], cap_cyc[k]);
        end
        checks++; if (ready_cyc !== 68) begin errors++; $display("FAIL basic_ready_cyc got %0d exp 68", ready_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b exp 0", busy); end
        for (int k = 0; k < 4; k++) begin
            rd_idx = 2'(k);
            tick();
            checks++; if (rd_data !== 16'd16) begin errors++; $display("FAIL basic_rd%0d got %h exp 0010", k, rd_data); end
            $display("basic: rd_data[%0d]=%h", k, rd_data);
        end
        rd_idx = 2'd0;
    endtask

    task automatic test_relu();
        set_neuron_w(0, 8'hFF);
        rd_idx = 2'd0;
        run_capture(1'b0, -1, 6'd0, 8'd0);
        checks++; if (cap_val[0] !== 16'hFFF0) begin errors++; $display("FAIL lin_neg_out0 got %h exp fff0", cap_val[0]); end
        checks++; if (cap_val[2] !== 16'd16)   begin errors++; $display("FAIL lin_neg_out2 got %h exp 0010", cap_val[2]); end
        $display("relu: linear neuron0=%h neuron2=%h", cap_val[0], cap_val[2]);
        run_capture(1'b1, -1, 6'd0, 8'd0);
        checks++; if (cap_val[0] !== 16'd0)  begin errors++; $display("FAIL relu_out0 got %h exp 0000", cap_val[0]); end
        checks++; if (cap_rd[0] !== 16'd0)   begin errors++; $display("FAIL relu_rd_fwd got %h exp 0000", cap_rd[0]); end
        checks++; if (cap_val[3] !== 16'd16) begin errors++; $display("FAIL relu_out3 got %h exp 0010", cap_val[3]); end
        $display("relu: relu neuron0=%h rd_data=%h neuron3=%h", cap_val[0], cap_rd[0], cap_val[3]);
        set_neuron_w(0, 8'd1);
    endtask

    task automatic test_saturation();
        load_all(8'd127, 8'd127);
        run_capture(1'b0, -1, 6'd0, 8'd0);
        checks++; if (cap_val[0] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_out0 got %h exp 7fff", cap_val[0]); end
        checks++; if (cap_val[3] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_out3 got %h exp 7fff", cap_val[3]); end
        $display("saturation: 127*127 sum -> %h", cap_val[0]);
        load_all(8'h80, 8'd127);
        run_capture(1'b0, -1, 6'd0, 8'd0);
        checks++; if (cap_val[0] !== 16'h8000) begin errors++; $display("FAIL sat_neg_out0 got %h exp 8000", cap_val[0]); end
        $display("saturation: -128*127 sum -> %h", cap_val[0]);
        run_capture(1'b1, -1, 6'd0, 8'd0);
        checks++; if (cap_val[1] !== 16'd0) begin errors++; $display("FAIL sat_neg_relu got %h exp 0000", cap_val[1]); end
        $display("saturation: -128*127 relu -> %h", cap_val[1]);
        load_all(8'd1, 8'd1);
    endtask

    task automatic test_shift();
        int found_cyc;
        logic [15:0] found_val;
        found_cyc = -1;
        found_val = 16'hDEAD;
        s_act_relu = 1'b0;
        for (int a = 0; a < 16; a++) begin
            s_in_we = 1'b1; s_w_we = 1'b1; s_in_addr = a[3:0]; s_w_addr = a[3:0]; s_wr_data = 8'd1;
            tick();
        end
        s_in_we = 1'b0; s_w_we = 1'b0;
        tick();
        s_start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (s_out_valid) begin
                found_cyc = c;
                found_val = s_out;
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL shift_ready got %b exp 1", s_ready); end
                break;
            end
        end
        s_start = 1'b0;
        checks++; if (found_val !== 16'd1) begin errors++; $display("FAIL shift_out got %h exp 0001", found_val); end
        checks++; if (found_cyc !== 17)    begin errors++; $display("FAIL shift_cyc got %0d exp 17", found_cyc); end
        $display("shift: SHIFT=4 out=%h at cycle %0d", found_val, found_cyc);
    endtask

    task automatic test_hold_start();
        int pulses;
        int rises;
        logic prev;
        start = 1'b0;
        tick(); tick();
        start = 1'b1;
        pulses = 0;
        rises = 0;
        prev = ready;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (out_valid) pulses++;
            if (ready && !prev) rises++;
            prev = ready;
        end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL hold_pulses got %0d exp 4", pulses); end
        checks++; if (rises !== 1)  begin errors++; $display("FAIL hold_ready_rises got %0d exp 1", rises); end
        $display("hold_start: pulses=%0d ready_rises=%0d", pulses, rises);
        run_capture(1'b0, -1, 6'd0, 8'd0);
        checks++; if (n_pulses !== 4)      begin errors++; $display("FAIL rerun_pulses got %0d exp 4", n_pulses); end
        checks++; if (cap_val[3] !== 16'd16) begin errors++; $display("FAIL rerun_out3 got %h exp 0010", cap_val[3]); end
        checks++; if (ready_cyc !== 68)    begin errors++; $display("FAIL rerun_ready_cyc got %0d exp 68", ready_cyc); end
        $display("hold_start: rerun pulses=%0d ready at %0d", n_pulses, ready_cyc);
    endtask

    task automatic test_reset_mid();
        start = 1'b0;
        tick(); tick();
        act_relu = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 30; c++) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL mid_ready got %b exp 0", ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
        checks++; if (out !== 16'd0)      begin errors++; $display("FAIL mid_out got %h exp 0000", out); end
        checks++; if (rd_data !== 16'd0)  begin errors++; $display("FAIL mid_rd_data got %h exp 0000", rd_data); end
        $display("reset_mid: busy=%b ready=%b out=%h", busy, ready, out);
        run_capture(1'b0, -1, 6'd0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            checks++; if (cap_val[k] !== 16'd16) begin errors++; $display("FAIL mid_rerun_out%0d got %h exp 0010", k, cap_val[k]); end
        end
        checks++; if (ready_cyc !== 68) begin errors++; $display("FAIL mid_rerun_ready got %0d exp 68", ready_cyc); end
        $display("reset_mid: rerun outs %h %h %h %h", cap_val[0], cap_val[1], cap_val[2], cap_val[3]);
    endtask

    task automatic test_busy_write();
        run_capture(1'b0, 5, 6'd48, 8'd5);
        checks++; if (cap_val[3] !== 16'd16) begin errors++; $display("FAIL busywr_same_run got %h exp 0010", cap_val[3]); end
        run_capture(1'b0, -1, 6'd0, 8'd0);
        checks++; if (cap_val[3] !== 16'd16) begin errors++; $display("FAIL busywr_next_run got %h exp 0010", cap_val[3]); end
        $display("busy_write: neuron3 after dropped write=%h", cap_val[3]);
        wr_both(1'b0, 4'd0, 1'b1, 6'd48, 8'd5);
        run_capture(1'b0, -1, 6'd0, 8'd0);
        checks++; if (cap_val[3] !== 16'd20) begin errors++; $display("FAIL idlewr_out3 got %h exp 0014", cap_val[3]); end
        checks++; if (cap_val[0] !== 16'd16) begin errors++; $display("FAIL idlewr_out0 got %h exp 0010", cap_val[0]); end
        $display("busy_write: neuron3 after idle write=%h", cap_val[3]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; act_relu = 1'b0; in_we = 1'b0; w_we = 1'b0;
        in_addr = '0; w_addr = '0; wr_data = '0; rd_idx = '0;
        s_start = 1'b0; s_act_relu = 1'b0; s_in_we = 1'b0; s_w_we = 1'b0;
        s_in_addr = '0; s_w_addr = '0; s_wr_data = '0; s_rd_idx = '0;
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_shift();
        test_hold_start();
        test_reset_mid();
        test_busy_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
